// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic-light controller:
// lamp phase encoding and the 7-segment glyph table.
package traffic_light_pkg;

   typedef enum logic [1:0] {GREEN, YELLOW, RED} light_state_t;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Index n holds the {dp,g,f,e,d,c,b,a} pattern for digit n
   localparam logic [9:0][7:0] SEG_TABLE = {
      8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
      8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

endpackage

// File: rtl/traffic_light_ctrl_seg7_decoder.sv
// Single-digit 7-segment encoder; non-decimal inputs render as blank.
module seg7_decoder
   import traffic_light_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (digit < 4'd10) seg = SEG_TABLE[digit];
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Fixed-cycle GREEN -> YELLOW -> RED controller with a per-second prescaler
// and a two-digit countdown display of the seconds left in the current phase.
module traffic_light_ctrl
   import traffic_light_pkg::*;
#(
   parameter int unsigned pSECOND_CNT_VALUE = 99,
   parameter int unsigned pGREEN_INIT_VAL   = 14,
   parameter int unsigned pYELLOW_INIT_VAL  = 2,
   parameter int unsigned pRED_INIT_VAL     = 17
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   output logic            green_light,
   output logic            yellow_light,
   output logic            red_light,
   output logic [1:0][7:0] display_led
);

   localparam int unsigned PW = (pSECOND_CNT_VALUE == 0) ? 1 : $clog2(pSECOND_CNT_VALUE + 1);
   localparam logic [PW-1:0] PRESC_TC = PW'(pSECOND_CNT_VALUE);
   localparam logic [6:0] GREEN_INIT  = 7'(pGREEN_INIT_VAL);
   localparam logic [6:0] YELLOW_INIT = 7'(pYELLOW_INIT_VAL);
   localparam logic [6:0] RED_INIT    = 7'(pRED_INIT_VAL);

   light_state_t  state_q, state_d;
   logic [6:0]    sec_cnt_q, sec_cnt_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic [2:0]    lamps_d;
   logic [3:0]    tens, units;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= GREEN;
         sec_cnt_q    <= GREEN_INIT;
         presc_q      <= '0;
         green_light  <= 1'b1;
         yellow_light <= 1'b0;
         red_light    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sec_cnt_q    <= sec_cnt_d;
         presc_q      <= presc_d;
         green_light  <= lamps_d[2];
         yellow_light <= lamps_d[1];
         red_light    <= lamps_d[0];
      end
   end

   // Lamps are decoded from the next state so they register on the same edge as the state
   always_comb begin
      tick      = en && (presc_q == PRESC_TC);
      presc_d   = presc_q;
      state_d   = state_q;
      sec_cnt_d = sec_cnt_q;
      lamps_d   = 3'b100;

      if (en) presc_d = tick ? '0 : presc_q + 1'b1;

      if (tick) begin
         if (sec_cnt_q != '0) begin
            sec_cnt_d = sec_cnt_q - 7'd1;
         end else begin
            case (state_q)
               GREEN:   begin state_d = YELLOW; sec_cnt_d = YELLOW_INIT; end
               YELLOW:  begin state_d = RED;    sec_cnt_d = RED_INIT;    end
               RED:     begin state_d = GREEN;  sec_cnt_d = GREEN_INIT;  end
               default: begin state_d = GREEN;  sec_cnt_d = GREEN_INIT;  end
            endcase
         end
      end

      case (state_d)
         GREEN:   lamps_d = 3'b100;
         YELLOW:  lamps_d = 3'b010;
         RED:     lamps_d = 3'b001;
         default: lamps_d = 3'b100;
      endcase
   end

   assign tens  = 4'(sec_cnt_q / 7'd10);
   assign units = 4'(sec_cnt_q % 7'd10);

   seg7_decoder u_tens (
      .digit (tens),
      .seg   (display_led[1])
   );

   seg7_decoder u_units (
      .digit (units),
      .seg   (display_led[0])
   );

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomised-enable bench for traffic_light_ctrl; expected lamps and display
// come from the position within the full light cycle, counted in enabled clocks.
module tb_traffic_light_ctrl;

   localparam int unsigned S_A = 99, G_A = 14, Y_A = 2, R_A = 17;
   localparam int unsigned S_B = 0,  G_B = 3,  Y_B = 0, R_B = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic g_a, y_a, r_a, g_b, y_b, r_b;
   logic [1:0][7:0] d_a, d_b;

   int unsigned n_a = 0, n_b = 0, ylen_b = 0;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   traffic_light_ctrl #(
      .pSECOND_CNT_VALUE (S_A),
      .pGREEN_INIT_VAL   (G_A),
      .pYELLOW_INIT_VAL  (Y_A),
      .pRED_INIT_VAL     (R_A)
   ) dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .green_light  (g_a),
      .yellow_light (y_a),
      .red_light    (r_a),
      .display_led  (d_a)
   );

   traffic_light_ctrl #(
      .pSECOND_CNT_VALUE (S_B),
      .pGREEN_INIT_VAL   (G_B),
      .pYELLOW_INIT_VAL  (Y_B),
      .pRED_INIT_VAL     (R_B)
   ) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (1'b1),
      .green_light  (g_b),
      .yellow_light (y_b),
      .red_light    (r_b),
      .display_led  (d_b)
   );

   function automatic logic [7:0] seg(input int unsigned v);
      case (v)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         8: return 8'h7F;  9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   // Returns {green,yellow,red, tens_seg, units_seg} after n enabled clocks
   function automatic logic [18:0] ref_out(input int unsigned n, s, g, y, r);
      int unsigned len, tg, ty, tr, t, rem;
      logic [2:0] lamps;
      len = s + 1;
      tg  = (g + 1) * len;
      ty  = (y + 1) * len;
      tr  = (r + 1) * len;
      t   = n % (tg + ty + tr);
      if (t < tg) begin
         lamps = 3'b100; rem = g - t / len;
      end else if (t < tg + ty) begin
         lamps = 3'b010; rem = y - (t - tg) / len;
      end else begin
         lamps = 3'b001; rem = r - (t - tg - ty) / len;
      end
      return {lamps, seg(rem / 10), seg(rem % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [18:0] ea, eb;
      ea = ref_out(n_a, S_A, G_A, Y_A, R_A);
      eb = ref_out(n_b, S_B, G_B, Y_B, R_B);
      check("a_lamps", {29'd0, g_a, y_a, r_a}, {29'd0, ea[18:16]});
      check("a_disp",  {16'd0, d_a}, {16'd0, ea[15:0]});
      check("a_onehot", $countones({g_a, y_a, r_a}), 1);
      check("a_dp", {30'd0, d_a[1][7], d_a[0][7]}, 0);
      check("b_lamps", {29'd0, g_b, y_b, r_b}, {29'd0, eb[18:16]});
      check("b_disp",  {16'd0, d_b}, {16'd0, eb[15:0]});
      check("b_onehot", $countones({g_b, y_b, r_b}), 1);
      check("b_dp", {30'd0, d_b[1][7], d_b[0][7]}, 0);
      if (y_b) begin
         check("b_yellow_disp", {16'd0, d_b}, 32'h3F3F);
         ylen_b++;
      end else begin
         if (ylen_b != 0) check("b_yellow_len", ylen_b, 1);
         ylen_b = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) begin
         if (en) n_a++;
         n_b++;
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [18:0] snap;
      int unsigned k;

      // Reset and idle with enable low
      repeat (5) step();
      check("rst_lamps", {29'd0, g_a, y_a, r_a}, 32'h4);
      check("rst_disp", {16'd0, d_a}, 32'h0666);
      rst_n = 1'b1;
      repeat (200) step();
      check("idle_disp", {16'd0, d_a}, 32'h0666);

      // Nominal cycle with explicit phase boundaries
      en = 1'b1;
      repeat (3600) begin
         step();
         case (n_a)
            1499: check("green_last", {13'd0, g_a, y_a, r_a, d_a}, {13'd0, 3'b100, 16'h3F3F});
            1500: check("yellow_first", {13'd0, g_a, y_a, r_a, d_a}, {13'd0, 3'b010, 16'h3F5B});
            1800: check("red_first", {13'd0, g_a, y_a, r_a, d_a}, {13'd0, 3'b001, 16'h0607});
            3600: check("green_again", {13'd0, g_a, y_a, r_a, d_a}, {13'd0, 3'b100, 16'h0666});
            default: ;
         endcase
      end

      // Enable gap mid-second
      k = 0;
      while ((n_a % 100) != 50 && k < 200) begin step(); k++; end
      check("gap_align", n_a % 100, 50);
      en = 1'b0;
      snap = {g_a, y_a, r_a, d_a};
      repeat (37) begin
         step();
         check("gap_hold", {13'd0, g_a, y_a, r_a, d_a}, {13'd0, snap});
      end
      en = 1'b1;

      // Randomised enable
      repeat (46000) begin
         en = ($urandom_range(0, 7) != 0);
         step();
      end
      en = 1'b1;

      // Asynchronous reset while red shows "09"
      k = 0;
      while (!(r_a && d_a == 16'h3F6F) && k < 10000) begin step(); k++; end
      check("find_red09", {15'd0, r_a, d_a}, {15'd0, 1'b1, 16'h3F6F});
      #2 rst_n = 1'b0;
      #1;
      check("arst_lamps", {29'd0, g_a, y_a, r_a}, 32'h4);
      check("arst_disp", {16'd0, d_a}, 32'h0666);
      n_a = 0;
      n_b = 0;
      ylen_b = 0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (500) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
